// File: rtl/uart_rx_cfg_if.sv
// Receive-side bundle of the configurable UART: serial line in, decoded word and status out.
// The receiver drives through master; the consumer (and the line source) use slave.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;
  logic                 busy;

  modport master (
    input  rx,
    output data, valid, parity_err, frame_err, break_det, busy
  );

  modport slave (
    output rx,
    input  data, valid, parity_err, frame_err, break_det, busy
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional even/odd parity, 1 or 2 stop bits,
// 3-sample majority per bit, with parity, framing and break reporting.
module uart_rx_cfg #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_cfg_if.master bus
);
  localparam int BIT_TIME = CLK_FREQ / BAUD_RATE;
  localparam int HALF     = BIT_TIME / 2;
  localparam int CW       = $clog2(BIT_TIME);
  localparam int IW       = $clog2(DATA_BITS);

  localparam logic [CW-1:0] C_LAST = CW'(BIT_TIME - 1);
  localparam logic [CW-1:0] C_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] C_S1   = CW'(HALF);
  localparam logic [CW-1:0] C_DEC  = CW'(HALF + 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
  localparam logic          ODD    = (PARITY == 2);
  localparam logic          TWO_SB = (STOP_BITS == 2);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9 || BIT_TIME < 8 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
      $error("uart_rx_cfg: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t               r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic                 r_stop_idx;
  logic [1:0]           r_samp;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_zero;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr_o;
  logic                 r_ferr_o;
  logic                 r_brk;
  logic                 r_busy;

  logic w_rx_s;
  logic w_maj;
  logic w_cnt_last;
  logic w_last_stop;
  logic w_ferr_now;
  logic w_zero_now;
  logic w_par_exp;

  assign w_rx_s      = r_sync2;
  // Third sample is the live synchronised line, so the vote resolves at cnt = HALF+1.
  assign w_maj       = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx_s) | (r_samp[1] & w_rx_s);
  assign w_cnt_last  = (r_cnt == C_LAST);
  assign w_last_stop = !TWO_SB || r_stop_idx;
  assign w_ferr_now  = r_ferr | ~w_maj;
  assign w_zero_now  = r_zero & ~w_maj;
  assign w_par_exp   = (^r_shift) ^ ODD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_stop_idx <= 1'b0;
      r_samp     <= 2'b11;
      r_shift    <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_zero     <= 1'b1;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_perr_o   <= 1'b0;
      r_ferr_o   <= 1'b0;
      r_brk      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_sync1 <= bus.rx;
      r_sync2 <= r_sync1;
      r_valid <= 1'b0;
      if (r_cnt == C_S0) r_samp[0] <= w_rx_s;
      if (r_cnt == C_S1) r_samp[1] <= w_rx_s;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (r_cnt == C_DEC && w_maj) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (w_cnt_last) begin
            r_state    <= S_DATA;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_zero     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          // Shift in from the top so the first (LSB) bit lands in bit 0 after the last one.
          if (r_cnt == C_DEC) begin
            r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
            if (w_maj) r_zero <= 1'b0;
          end
          if (w_cnt_last) begin
            r_cnt <= '0;
            if (r_idx == I_LAST) begin
              r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (r_cnt == C_DEC) begin
            if (w_maj != w_par_exp) r_perr <= 1'b1;
            if (w_maj) r_zero <= 1'b0;
          end
          if (w_cnt_last) begin
            r_state <= S_STOP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (r_cnt == C_DEC && w_last_stop) begin
            // Leave at mid-bit so a start edge right after the stop bit is not missed.
            r_valid  <= 1'b1;
            r_data   <= r_shift;
            r_perr_o <= r_perr;
            r_ferr_o <= w_ferr_now;
            r_brk    <= w_zero_now;
            r_cnt    <= '0;
            if (w_ferr_now) begin
              r_state <= S_WAIT_HIGH;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (r_cnt == C_DEC) begin
            r_ferr <= w_ferr_now;
            r_zero <= w_zero_now;
            r_cnt  <= r_cnt + 1'b1;
          end else if (w_cnt_last) begin
            r_stop_idx <= 1'b1;
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_WAIT_HIGH: begin
          r_cnt <= '0;
          if (w_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.data       = r_data;
  assign bus.valid      = r_valid;
  assign bus.parity_err = r_perr_o;
  assign bus.frame_err  = r_ferr_o;
  assign bus.break_det  = r_brk;
  assign bus.busy       = r_busy;
endmodule
